// File: rtl/frame_scheduler.sv
`timescale 1ns/1ps
// frame_scheduler
//   Double-buffered frame sequencer. Each frame asks game logic to advance
//   its tables, resets and then runs the painter into the back buffer, and
//   swaps buffers on the first vsync after the painter finishes. A vsync
//   that arrives with no finished frame is counted as a drop.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | parked; painter held in reset; leaves when enable is high
//   UPDATE | update_req pulsed on entry; waiting for update_ack
//   START  | painter held in reset for two cycles
//   PAINT  | painter running, framebuffer writes enabled
//   READY  | frame complete, painter held in reset, waiting for vsync
//
// Ports
//   clk_33m          : single clock
//   rst              : asynchronous active-high reset
//   enable           : allows new frames to start
//   vsync            : one-cycle vertical-blank pulse
//   update_req       : one-cycle request to advance sprite/pos tables
//   update_ack       : level, tables stable
//   painter_rst      : painter reset
//   painter_finished : painter done flag
//   write_enable     : gates painter writes
//   write_buffer     : buffer the painter writes
//   display_buffer   : buffer the display reads (always ~write_buffer)
//   frame_count      : completed swaps, wraps
//   drop_count       : vsyncs with no frame ready, saturates
//   busy             : high outside IDLE

module frame_scheduler #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk_33m,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   vsync,
    output logic                   update_req,
    input  logic                   update_ack,
    output logic                   painter_rst,
    input  logic                   painter_finished,
    output logic                   write_enable,
    output logic                   write_buffer,
    output logic                   display_buffer,
    output logic [COUNT_WIDTH-1:0] frame_count,
    output logic [COUNT_WIDTH-1:0] drop_count,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UPDATE = 3'd1,
        S_START  = 3'd2,
        S_PAINT  = 3'd3,
        S_READY  = 3'd4
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
    // START lasts two cycles: the counter is loaded with 1 and START exits
    // when it reaches zero.
    localparam logic [1:0] START_LOAD = 2'd1;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] start_cnt;
    logic [1:0] start_cnt_nxt;
    logic       paint_armed;
    logic       finish_ok;
    logic       swap;
    logic       drop;

    // The painter's finished flag may still be stale from the previous frame
    // during the first PAINT cycle, so it only counts once PAINT has been
    // occupied for a full cycle.
    assign finish_ok = (state == S_PAINT) && paint_armed && painter_finished;

    assign display_buffer = ~write_buffer;

    always_comb begin
        state_nxt     = state;
        start_cnt_nxt = start_cnt;
        swap          = 1'b0;
        drop          = 1'b0;
        case (state)
            S_IDLE: begin
                drop = vsync;
                if (enable) begin
                    state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                drop = vsync;
                if (update_ack) begin
                    state_nxt     = S_START;
                    start_cnt_nxt = START_LOAD;
                end
            end
            S_START: begin
                drop = vsync;
                if (start_cnt == 2'd0) begin
                    state_nxt = S_PAINT;
                end else begin
                    start_cnt_nxt = start_cnt - 2'd1;
                end
            end
            S_PAINT: begin
                if (finish_ok) begin
                    if (vsync) begin
                        // finished exactly at vblank: swap now, skip READY
                        swap      = 1'b1;
                        state_nxt = enable ? S_UPDATE : S_IDLE;
                    end else begin
                        state_nxt = S_READY;
                    end
                end else begin
                    drop = vsync;
                end
            end
            S_READY: begin
                if (vsync) begin
                    swap      = 1'b1;
                    state_nxt = enable ? S_UPDATE : S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up exactly
    // with the state register.
    always_ff @(posedge clk_33m or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            start_cnt    <= 2'd0;
            paint_armed  <= 1'b0;
            update_req   <= 1'b0;
            painter_rst  <= 1'b1;
            write_enable <= 1'b0;
            busy         <= 1'b0;
            write_buffer <= 1'b0;
            frame_count  <= '0;
            drop_count   <= '0;
        end else begin
            state        <= state_nxt;
            start_cnt    <= start_cnt_nxt;
            paint_armed  <= (state == S_PAINT);
            update_req   <= (state_nxt == S_UPDATE) && (state != S_UPDATE);
            painter_rst  <= (state_nxt != S_PAINT);
            write_enable <= (state_nxt == S_PAINT);
            busy         <= (state_nxt != S_IDLE);
            if (swap) begin
                write_buffer <= ~write_buffer;
                frame_count  <= frame_count + CNT_ONE;
            end
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_ONE;
            end
        end
    end

endmodule
